hazard_stall_unit: RTL and testbench

// - Pipeline control block upstream of the D/X bypass logic; decides what enters the D/X latch.
// - Detects load-use hazards, sequences multi-cycle mul/div in X, and flushes on taken branch.
// - Drives PC/F-D hold, D/X bubble insert, F-D/D-X flush and multdiv start pulses.

---
 rtl/hazard_stall_unit_pkg.sv | 57 +++++
 rtl/hazard_stall_unit_if.sv | 37 +++
 rtl/hazard_stall_unit_reg_read_decode.sv | 78 +++++++
 rtl/hazard_stall_unit.sv | 148 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// ============================================================================
// Module : hazard_stall_unit_pkg
// Brief  : ISA field positions, opcode/aluop constants and multdiv FSM states
//          shared by the hazard/stall unit and the D/X bypass logic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_stall_unit_pkg;

    localparam logic [31:0] NOP = 32'd0;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int RS_HI    = 21;
    localparam int RS_LO    = 17;
    localparam int RT_HI    = 16;
    localparam int RT_LO    = 12;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 2;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_mul(input logic [4:0] op, input logic [4:0] aluop);
        return (op == OP_ALU) && (aluop == ALUOP_MUL);
    endfunction

    function automatic logic is_div(input logic [4:0] op, input logic [4:0] aluop);
        return (op == OP_ALU) && (aluop == ALUOP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
// Module : hazard_stall_unit_if
// Brief  : Pipeline-side bundle between datapath latches and hazard/stall unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if;
    logic [31:0] fd_ir;
    logic [31:0] dx_ir;
    logic        branch_taken;
    logic        md_ready;

    logic        stall_pc;
    logic        stall_fd;
    logic        bubble_dx;
    logic        flush_fd;
    logic        md_start_mult;
    logic        md_start_div;
    logic        stall_dx;
    logic        md_done;
    logic        md_timeout;

    modport master (
        output fd_ir, dx_ir, branch_taken, md_ready,
        input  stall_pc, stall_fd, bubble_dx, flush_fd,
               md_start_mult, md_start_div, stall_dx, md_done, md_timeout
    );

    modport slave (
        input  fd_ir, dx_ir, branch_taken, md_ready,
        output stall_pc, stall_fd, bubble_dx, flush_fd,
               md_start_mult, md_start_div, stall_dx, md_done, md_timeout
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit_reg_read_decode.sv
// ============================================================================
// Module : reg_read_decode
// Brief  : Source-register read set of one instruction (up to two operands).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_read_decode
    import hazard_stall_unit_pkg::*;
(
    input  logic [31:0] ir,
    output logic        uses_a,
    output logic [4:0]  src_a,
    output logic        uses_b,
    output logic [4:0]  src_b
);

    logic [4:0] w_op;
    logic [4:0] w_rd;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_unused_bits;

    assign w_op          = ir[OP_HI:OP_LO];
    assign w_rd          = ir[RD_HI:RD_LO];
    assign w_rs          = ir[RS_HI:RS_LO];
    assign w_rt          = ir[RT_HI:RT_LO];
    assign w_unused_bits = ^ir[11:0];

    always_comb begin
        uses_a = 1'b0;
        src_a  = REG_ZERO;
        uses_b = 1'b0;
        src_b  = REG_ZERO;
        case (w_op)
            OP_ALU: begin
                uses_a = 1'b1;
                src_a  = w_rs;
                uses_b = 1'b1;
                src_b  = w_rt;
            end
            OP_ADDI, OP_LW: begin
                uses_a = 1'b1;
                src_a  = w_rs;
            end
            // store data register lives in the rd field
            OP_SW: begin
                uses_a = 1'b1;
                src_a  = w_rs;
                uses_b = 1'b1;
                src_b  = w_rd;
            end
            OP_BNE, OP_BLT: begin
                uses_a = 1'b1;
                src_a  = w_rd;
                uses_b = 1'b1;
                src_b  = w_rs;
            end
            OP_JR: begin
                uses_a = 1'b1;
                src_a  = w_rd;
            end
            OP_BEX: begin
                uses_a = 1'b1;
                src_a  = REG_STATUS;
            end
            OP_J, OP_JAL, OP_SETX: begin
                uses_a = 1'b0;
            end
            default: begin
                uses_a = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module : hazard_stall_unit
// Brief  : Load-use interlock, taken-branch flush and multi-cycle mul/div
//          sequencing in front of the D/X latch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 40
)(
    input  logic                clock,
    input  logic                reset,
    hazard_stall_unit_if.slave  hz
);

    localparam int CNT_W = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_MAX_CYCLES);

    md_state_e        r_state;
    md_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_timeout;
    logic             w_timeout_next;

    logic             w_uses_a;
    logic             w_uses_b;
    logic [4:0]       w_src_a;
    logic [4:0]       w_src_b;

    logic [4:0]       w_dx_op;
    logic [4:0]       w_dx_rd;
    logic [4:0]       w_dx_aluop;
    logic             w_dx_mul;
    logic             w_dx_div;
    logic             w_load_use;
    logic             w_unused_dx;

    logic             w_stall_pc;
    logic             w_stall_fd;
    logic             w_bubble_dx;
    logic             w_flush_fd;
    logic             w_start_mult;
    logic             w_start_div;
    logic             w_stall_dx;
    logic             w_md_done;

    reg_read_decode u_fd_decode (
        .ir     (hz.fd_ir),
        .uses_a (w_uses_a),
        .src_a  (w_src_a),
        .uses_b (w_uses_b),
        .src_b  (w_src_b)
    );

    assign w_dx_op     = hz.dx_ir[OP_HI:OP_LO];
    assign w_dx_rd     = hz.dx_ir[RD_HI:RD_LO];
    assign w_dx_aluop  = hz.dx_ir[ALUOP_HI:ALUOP_LO];
    assign w_dx_mul    = is_mul(w_dx_op, w_dx_aluop);
    assign w_dx_div    = is_div(w_dx_op, w_dx_aluop);
    assign w_unused_dx = ^{hz.dx_ir[RS_HI:ALUOP_HI+1], hz.dx_ir[1:0]};

    assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != REG_ZERO) &&
                        ((w_uses_a && (w_src_a == w_dx_rd)) ||
                         (w_uses_b && (w_src_b == w_dx_rd)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Priority: busy mul/div stalls, then taken-branch flush, then load-use.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_timeout_next = r_timeout;
        w_stall_pc     = 1'b0;
        w_stall_fd     = 1'b0;
        w_bubble_dx    = 1'b0;
        w_flush_fd     = 1'b0;
        w_start_mult   = 1'b0;
        w_start_div    = 1'b0;
        w_stall_dx     = 1'b0;
        w_md_done      = 1'b0;
        if (!reset) begin
            case (r_state)
                MD_IDLE: begin
                    if ((w_dx_mul || w_dx_div) && !hz.branch_taken) begin
                        w_start_mult = w_dx_mul;
                        w_start_div  = w_dx_div;
                        w_stall_pc   = !hz.md_ready;
                        w_stall_fd   = !hz.md_ready;
                        w_stall_dx   = !hz.md_ready;
                        w_state_next = MD_BUSY;
                        w_cnt_next   = '0;
                    end else if (hz.branch_taken) begin
                        w_flush_fd  = 1'b1;
                        w_bubble_dx = 1'b1;
                    end else if (w_load_use) begin
                        w_stall_pc  = 1'b1;
                        w_stall_fd  = 1'b1;
                        w_bubble_dx = 1'b1;
                    end
                end
                MD_BUSY: begin
                    w_stall_pc = 1'b1;
                    w_stall_fd = 1'b1;
                    w_stall_dx = !hz.md_ready;
                    w_md_done  = hz.md_ready;
                    if (r_cnt == CNT_MAX) begin
                        w_timeout_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                    if (hz.md_ready) begin
                        w_state_next = MD_IDLE;
                    end
                end
                default: begin
                    w_state_next = MD_IDLE;
                end
            endcase
        end
    end

    assign hz.stall_pc      = w_stall_pc;
    assign hz.stall_fd      = w_stall_fd;
    assign hz.bubble_dx     = w_bubble_dx;
    assign hz.flush_fd      = w_flush_fd;
    assign hz.md_start_mult = w_start_mult;
    assign hz.md_start_div  = w_start_div;
    assign hz.stall_dx      = w_stall_dx;
    assign hz.md_done       = w_md_done;
    assign hz.md_timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module : tb_hazard_stall_unit
// Brief  : Scoreboard bench for hazard_stall_unit with a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

    localparam int MAXC = 4;

    logic clock = 1'b0;
    logic reset;

    hazard_stall_unit_if hz ();

    hazard_stall_unit #(.MD_MAX_CYCLES(MAXC)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] sb[$];
    logic [8:0] mon_exp;
    logic [8:0] mon_got;

    bit  m_busy = 1'b0;
    bit  m_to   = 1'b0;
    int  m_cnt  = 0;

    function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                       input int rt, input int al);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(al), 2'b00};
    endfunction

    // Source registers read by an instruction, listed straight from the ISA table
    function automatic bit reads_reg(input logic [31:0] ir, input int r);
        int op = int'(ir[31:27]);
        int rd = int'(ir[26:22]);
        int rs = int'(ir[21:17]);
        int rt = int'(ir[16:12]);
        int srcs[$];
        case (op)
            0:       srcs = '{rs, rt};
            5, 8:    srcs = '{rs};
            7:       srcs = '{rs, rd};
            2, 6:    srcs = '{rd, rs};
            4:       srcs = '{rd};
            22:      srcs = '{30};
            default: srcs = {};
        endcase
        foreach (srcs[i]) if (srcs[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic predict(input logic [31:0] fd, input logic [31:0] dx,
                           input logic br, input logic rdy, input logic rst);
        bit sp = 0, sf = 0, bub = 0, fl = 0, sm = 0, sd = 0, sdx = 0, dn = 0, to = 0;
        int dop = int'(dx[31:27]);
        int drd = int'(dx[26:22]);
        int dal = int'(dx[6:2]);
        bit dmul = (dop == 0) && (dal == 6);
        bit ddiv = (dop == 0) && (dal == 7);
        if (rst) begin
            m_busy = 0;
            m_cnt  = 0;
            m_to   = 0;
        end else begin
            to = m_to;
            if (m_busy) begin
                sp  = 1;
                sf  = 1;
                sdx = !rdy;
                dn  = rdy;
                if (m_cnt == MAXC) m_to = 1;
                if (m_cnt < MAXC) m_cnt++;
                if (rdy) m_busy = 0;
            end else if ((dmul || ddiv) && !br) begin
                sm = dmul;
                sd = ddiv;
                sp = !rdy;
                sf = !rdy;
                sdx = !rdy;
                m_busy = 1;
                m_cnt  = 0;
            end else if (br) begin
                fl  = 1;
                bub = 1;
            end else if (dop == 8 && drd != 0 && reads_reg(fd, drd)) begin
                sp  = 1;
                sf  = 1;
                bub = 1;
            end
        end
        sb.push_back({sp, sf, bub, fl, sm, sd, sdx, dn, to});
    endtask

    task automatic step(input logic [31:0] fd, input logic [31:0] dx,
                        input logic br, input logic rdy, input logic rst);
        @(posedge clock);
        #1;
        reset           = rst;
        hz.fd_ir        = fd;
        hz.dx_ir        = dx;
        hz.branch_taken = br;
        hz.md_ready     = rdy;
        cyc++;
        predict(fd, dx, br, rdy, rst);
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_got = {hz.stall_pc, hz.stall_fd, hz.bubble_dx, hz.flush_fd,
                       hz.md_start_mult, hz.md_start_div, hz.stall_dx,
                       hz.md_done, hz.md_timeout};
            total++;
            if (mon_got !== mon_exp) begin
                bad++;
                $display("FAIL outputs cyc=%0d got=%b want=%b (pc fd bub flush smul sdiv sdx done tmo)",
                         cyc, mon_got, mon_exp);
            end
        end
    end

    function automatic logic [31:0] rand_ir();
        int sel = $urandom_range(0, 10);
        int ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};
        return mk(ops[sel], $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_dx();
        int k = $urandom_range(0, 11);
        if (k < 3) return mk(8, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
        if (k == 3) return mk(0, $urandom_range(1, 7), 1, 2, 6);
        if (k == 4) return mk(0, $urandom_range(1, 7), 1, 2, 7);
        return rand_ir();
    endfunction

    logic [31:0] add_r5, lw_r5, lw_r0, add_r0, lw_r7, sw_r7, j100, mul_i, div_i;
    logic [31:0] held_dx, fd_r, dx_r;
    logic        br_r, rdy_r, rst_r;

    initial begin
        reset           = 1'b1;
        hz.fd_ir        = '0;
        hz.dx_ir        = '0;
        hz.branch_taken = 1'b0;
        hz.md_ready     = 1'b0;

        add_r5 = mk(0, 1, 5, 2, 0);
        lw_r5  = mk(8, 5, 4, 0, 0);
        lw_r0  = mk(8, 0, 4, 0, 0);
        add_r0 = mk(0, 1, 0, 2, 0);
        lw_r7  = mk(8, 7, 4, 0, 0);
        sw_r7  = mk(7, 7, 3, 0, 0);
        j100   = mk(1, 0, 0, 0, 0) | 32'd100;
        mul_i  = mk(0, 3, 1, 2, 6);
        div_i  = mk(0, 3, 1, 2, 7);

        step('0, '0, 0, 0, 1);
        step('0, '0, 0, 0, 1);
        step('0, '0, 0, 0, 0);

        step(add_r5, lw_r5, 0, 0, 0);
        step(add_r5, '0, 0, 0, 0);
        step(add_r0, lw_r0, 0, 0, 0);
        step(sw_r7, lw_r7, 0, 0, 0);
        step(j100, lw_r7, 0, 0, 0);
        step(add_r5, lw_r5, 1, 0, 0);

        for (int i = 0; i <= 6; i++) step(add_r5, (i < 6) ? mul_i : '0, 0, (i == 5), 0);
        for (int i = 0; i <= 6; i++) step(add_r5, (i < 6) ? div_i : '0, 0, (i == 5), 0);

        for (int i = 0; i < 9; i++) step(add_r5, mul_i, 0, 0, 0);
        step(add_r5, mul_i, 0, 0, 1);
        step(add_r5, mul_i, 0, 0, 1);
        step(add_r5, '0, 0, 1, 0);
        step(add_r5, '0, 0, 0, 0);

        held_dx = '0;
        for (int i = 0; i < 500; i++) begin
            fd_r  = rand_ir();
            br_r  = ($urandom_range(0, 5) == 0);
            rst_r = ($urandom_range(0, 79) == 0);
            if (m_busy) begin
                dx_r  = held_dx;
                rdy_r = ($urandom_range(0, 4) == 0);
            end else begin
                dx_r  = rand_dx();
                rdy_r = ($urandom_range(0, 1) == 1);
                if (dx_r[31:27] == 5'd0 && (dx_r[6:2] == 5'd6 || dx_r[6:2] == 5'd7) && !br_r)
                    rdy_r = 1'b0;
            end
            held_dx = dx_r;
            step(fd_r, dx_r, br_r, rdy_r, rst_r);
        end

        repeat (2) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
